// File: rtl/mem_seq_pkg.sv
// Shared types and defaults for the memory sequencer.
// MEM_SEQ_TIMEOUT_EN adds the ERR state used by the optional ACCESS timeout.
package mem_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ADDR   = 3'd1,
    ST_ACCESS = 3'd2,
    ST_LATCH  = 3'd3,
    ST_DONE   = 3'd4
`ifdef MEM_SEQ_TIMEOUT_EN
    , ST_ERR  = 3'd5
`endif
  } state_t;

  localparam int DEF_WAIT_CYCLES    = 1;
  localparam int DEF_TIMEOUT_CYCLES = 15;
  localparam int WAIT_CNT_W         = 4;
  localparam int TIMEOUT_CNT_W      = 8;

endpackage

// File: rtl/mem_seq_cnt.sv
// Loadable down-counter that saturates at zero and flags when it is empty.
module mem_seq_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_zero
);

  logic [W-1:0] r_count;

  // Load wins over decrement so a fresh transaction always restarts the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/mem_seq.sv
// Moore sequencer driving MAR/MDR strobes and memory read/write handshakes.
// Define MEM_SEQ_TIMEOUT_EN to abort ACCESS into ERR after TIMEOUT_CYCLES.
module mem_seq
  import mem_seq_pkg::*;
#(
  parameter int DATA_WIDTH     = 4,
  parameter int WAIT_CYCLES    = DEF_WAIT_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic req,
  input  logic we,
  input  logic mem_ack,
  output logic mar_en,
  output logic mdr_en,
  output logic mdr_alu_n,
  output logic mem_rd,
  output logic mem_wr,
  output logic busy,
  output logic done,
  output logic err
);

  generate
    if (DATA_WIDTH < 1 || WAIT_CYCLES < 0 || WAIT_CYCLES > 15 ||
        TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_param
      $error("mem_seq: parameter out of range");
    end
  endgenerate

  localparam logic [WAIT_CNT_W-1:0] WaitLoad = WAIT_CNT_W'(WAIT_CYCLES);

  state_t r_state;
  state_t w_next_state;
  logic   r_we_q;
  logic   w_wait_zero;
  logic   w_access_exit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_we_q  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (r_state == ST_IDLE && req) begin
        r_we_q <= we;
      end
    end
  end

  // Wait counter: armed in ADDR so ACCESS lasts at least WAIT_CYCLES+1 cycles.
  mem_seq_cnt #(.W(WAIT_CNT_W)) u_wait_cnt (
    .clk        (clk),
    .rst        (rst),
    .i_load     (r_state == ST_ADDR),
    .i_load_val (WaitLoad),
    .i_dec      (r_state == ST_ACCESS),
    .o_zero     (w_wait_zero)
  );

  assign w_access_exit = (r_state == ST_ACCESS) && w_wait_zero && mem_ack;

`ifdef MEM_SEQ_TIMEOUT_EN
  localparam logic [TIMEOUT_CNT_W-1:0] TimeoutLoad = TIMEOUT_CNT_W'(TIMEOUT_CYCLES - 1);

  logic w_timeout_zero;

  // Loaded with TIMEOUT_CYCLES-1 so it empties in the last permitted ACCESS cycle.
  mem_seq_cnt #(.W(TIMEOUT_CNT_W)) u_timeout_cnt (
    .clk        (clk),
    .rst        (rst),
    .i_load     (r_state == ST_ADDR),
    .i_load_val (TimeoutLoad),
    .i_dec      (r_state == ST_ACCESS),
    .o_zero     (w_timeout_zero)
  );
`endif

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:   if (req) w_next_state = ST_ADDR;
      ST_ADDR:   w_next_state = ST_ACCESS;
      ST_ACCESS: begin
        if (w_access_exit) begin
          w_next_state = ST_LATCH;
        end
`ifdef MEM_SEQ_TIMEOUT_EN
        else if (w_timeout_zero) begin
          w_next_state = ST_ERR;
        end
`endif
      end
      ST_LATCH:  w_next_state = ST_DONE;
      ST_DONE:   w_next_state = ST_IDLE;
`ifdef MEM_SEQ_TIMEOUT_EN
      ST_ERR:    w_next_state = ST_IDLE;
`endif
      default:   w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    mar_en    = 1'b0;
    mdr_en    = 1'b0;
    mdr_alu_n = 1'b0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    busy      = (r_state != ST_IDLE);
    done      = 1'b0;
    err       = 1'b0;
    case (r_state)
      ST_ADDR: begin
        mar_en = 1'b1;
        mdr_en = r_we_q;
      end
      ST_ACCESS: begin
        mem_rd = ~r_we_q;
        mem_wr = r_we_q;
      end
      ST_LATCH: begin
        mdr_en    = ~r_we_q;
        mdr_alu_n = ~r_we_q;
      end
      ST_DONE: begin
        done      = 1'b1;
        mdr_alu_n = ~r_we_q;
      end
`ifdef MEM_SEQ_TIMEOUT_EN
      ST_ERR:  err = 1'b1;
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_seq.sv
// Bench for mem_seq: instance u0 uses WAIT_CYCLES=1/TIMEOUT_CYCLES=4, u1 uses WAIT_CYCLES=0.
// Output vectors are packed as {mar_en, mdr_en, mdr_alu_n, mem_rd, mem_wr, busy, done}.
module tb_mem_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req0 = 1'b0, we0 = 1'b0, ack0 = 1'b0;
  logic req1 = 1'b0, we1 = 1'b0, ack1 = 1'b0;
  logic mar0, mdr0, alu0, rd0, wr0, busy0, done0, err0;
  logic mar1, mdr1, alu1, rd1, wr1, busy1, done1, err1;

  int compares = 0;
  int fails = 0;
  int edgeCnt = 0;
  bit sbOn = 1'b0;
  bit errAllowed = 1'b0;
  int expQ[$];

  logic [6:0] out0, out1;
  assign out0 = {mar0, mdr0, alu0, rd0, wr0, busy0, done0};
  assign out1 = {mar1, mdr1, alu1, rd1, wr1, busy1, done1};

  always #5 clk = ~clk;

  always @(posedge clk) edgeCnt <= edgeCnt + 1;

  mem_seq #(.DATA_WIDTH(4), .WAIT_CYCLES(1), .TIMEOUT_CYCLES(4)) u0 (
    .clk(clk), .rst(rst), .req(req0), .we(we0), .mem_ack(ack0),
    .mar_en(mar0), .mdr_en(mdr0), .mdr_alu_n(alu0), .mem_rd(rd0), .mem_wr(wr0),
    .busy(busy0), .done(done0), .err(err0)
  );

  mem_seq #(.DATA_WIDTH(4), .WAIT_CYCLES(0), .TIMEOUT_CYCLES(15)) u1 (
    .clk(clk), .rst(rst), .req(req1), .we(we1), .mem_ack(ack1),
    .mar_en(mar1), .mdr_en(mdr1), .mdr_alu_n(alu1), .mem_rd(rd1), .mem_wr(wr1),
    .busy(busy1), .done(done1), .err(err1)
  );

  typedef struct {
    bit         dut;
    bit         req;
    bit         we;
    bit         ack;
    logic [6:0] exp;
    string      name;
  } vec_t;

  vec_t vecs[11];

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    compares++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h at edge %0d", name, got, exp, edgeCnt);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input bit dut, input bit r, input bit w, input bit a);
    if (dut) begin
      req1 = r; we1 = w; ack1 = a;
    end else begin
      req0 = r; we0 = w; ack0 = a;
    end
    tick();
  endtask

  always @(negedge clk) begin
    checkOutput("rdWrExclusive0", rd0 & wr0, 0);
    checkOutput("rdWrExclusive1", rd1 & wr1, 0);
    if (err1) checkOutput("unexpectedErr1", err1, 0);
    if (err0 && !errAllowed) checkOutput("unexpectedErr0", err0, 0);
    if (sbOn && done0) begin
      if (expQ.size() == 0) checkOutput("unexpectedDone", done0, 0);
      else checkOutput("doneEdge", edgeCnt, expQ.pop_front());
    end
  end

  initial begin
    int k;
    int rdCnt;
    bit errSeen;

    vecs[0]  = '{0, 1, 0, 1, 7'b1000010, "rdAddr"};
    vecs[1]  = '{0, 0, 0, 1, 7'b0001010, "rdAccess1"};
    vecs[2]  = '{0, 0, 0, 1, 7'b0001010, "rdAccess2"};
    vecs[3]  = '{0, 0, 0, 1, 7'b0110010, "rdLatch"};
    vecs[4]  = '{0, 0, 0, 1, 7'b0010011, "rdDone"};
    vecs[5]  = '{0, 0, 0, 1, 7'b0000000, "rdIdle"};
    vecs[6]  = '{1, 1, 1, 1, 7'b1100010, "wrAddr"};
    vecs[7]  = '{1, 0, 1, 1, 7'b0000110, "wrAccess"};
    vecs[8]  = '{1, 0, 1, 1, 7'b0000010, "wrLatch"};
    vecs[9]  = '{1, 0, 1, 1, 7'b0000011, "wrDone"};
    vecs[10] = '{1, 0, 1, 1, 7'b0000000, "wrIdle"};

    tick();
    tick();
    checkOutput("resetOut0", out0, 0);
    checkOutput("resetOut1", out1, 0);
    checkOutput("resetErr0", err0, 0);
    req0 = 1'b1;
    tick();
    checkOutput("reqIgnoredInReset", busy0, 0);
    req0 = 1'b0;
    rst  = 1'b0;

    $display("[TB] table vectors");
    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i].dut, vecs[i].req, vecs[i].we, vecs[i].ack);
      checkOutput(vecs[i].name, vecs[i].dut ? out1 : out0, {25'b0, vecs[i].exp});
    end

    $display("[TB] back-to-back reads");
    sbOn = 1'b1;
    ack0 = 1'b1; we0 = 1'b0; req0 = 1'b1;
    k = edgeCnt;
    expQ.push_back(k + 5);
    expQ.push_back(k + 11);
    expQ.push_back(k + 17);
    repeat (13) tick();
    req0 = 1'b0;
    repeat (2) tick();
    req0 = 1'b1;
    tick();
    req0 = 1'b0;
    repeat (12) tick();
    checkOutput("b2bQueueEmpty", expQ.size(), 0);
    checkOutput("b2bIdle", busy0, 0);

    $display("[TB] delayed mem_ack");
    ack0 = 1'b0; we0 = 1'b0; req0 = 1'b1;
    tick();
    req0 = 1'b0;
    rdCnt = 0;
    repeat (6) begin
      tick();
      rdCnt += int'(rd0);
    end
    tick();
    ack0 = 1'b1;
    expQ.push_back(edgeCnt + 2);
    rdCnt += int'(rd0);
    repeat (4) begin
      tick();
      rdCnt += int'(rd0);
    end
    checkOutput("slowAckRdCycles", rdCnt, 7);
    checkOutput("slowAckQueueEmpty", expQ.size(), 0);

    $display("[TB] mem_ack never arrives");
    ack0 = 1'b0; we0 = 1'b0; req0 = 1'b1;
    tick();
    req0 = 1'b0;
    rdCnt = 0;
`ifdef MEM_SEQ_TIMEOUT_EN
    errAllowed = 1'b1;
    repeat (4) begin
      tick();
      rdCnt += int'(rd0);
    end
    tick();
    checkOutput("errPulse", err0, 1);
    checkOutput("noDoneInErr", done0, 0);
    checkOutput("timeoutRdCycles", rdCnt, 4);
    tick();
    checkOutput("errOneCycle", err0, 0);
    checkOutput("idleAfterErr", busy0, 0);
    errAllowed = 1'b0;
`else
    errSeen = 1'b0;
    repeat (20) begin
      tick();
      if (err0) errSeen = 1'b1;
    end
    checkOutput("hangNoErr", errSeen, 0);
    checkOutput("hangBusy", busy0, 1);
    checkOutput("hangRd", rd0, 1);
    ack0 = 1'b1;
    expQ.push_back(edgeCnt + 2);
    repeat (4) tick();
    checkOutput("hangReleaseQueueEmpty", expQ.size(), 0);
`endif

    $display("[TB] reset during write access");
    ack0 = 1'b0; we0 = 1'b1; req0 = 1'b1;
    tick();
    req0 = 1'b0;
    tick();
    tick();
    checkOutput("wrInAccess", wr0, 1);
    #2 rst = 1'b1;
    #1;
    checkOutput("wrDropAsync", wr0, 0);
    checkOutput("busyInReset", busy0, 0);
    tick();
    tick();
    rst = 1'b0;
    we0 = 1'b0; ack0 = 1'b1; req0 = 1'b1;
    k = edgeCnt;
    expQ.push_back(k + 5);
    tick();
    req0 = 1'b0;
    repeat (7) tick();
    checkOutput("readAfterResetQueueEmpty", expQ.size(), 0);
    checkOutput("readAfterResetIdle", busy0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
    $finish;
  end

endmodule
